// File: rtl/matmul.sv
// matmul: tiled signed fixed-point matrix multiply.
// A tiles stream once, row-major. Each held A tile (i,k) meets the B tiles
// (k,0..DB0-1); products accumulate per B tile column, and the last k of a
// tile row emits the cast output tile (i,j).
module matmul #(
  parameter int A_TOTAL_DIM0   = 4,
  parameter int A_TOTAL_DIM1   = 4,
  parameter int B_TOTAL_DIM0   = 4,
  parameter int B_TOTAL_DIM1   = 4,
  parameter int A_COMPUTE_DIM0 = 2,
  parameter int A_COMPUTE_DIM1 = 2,
  parameter int B_COMPUTE_DIM0 = 2,
  parameter int B_COMPUTE_DIM1 = 2,
  parameter int A_WIDTH        = 8,
  parameter int A_FRAC_WIDTH   = 0,
  parameter int B_WIDTH        = 8,
  parameter int B_FRAC_WIDTH   = 0,
  parameter int OUT_WIDTH      = 16,
  parameter int OUT_FRAC_WIDTH = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [A_WIDTH-1:0]   a_data [A_COMPUTE_DIM0*A_COMPUTE_DIM1],
  input  logic                        a_valid,
  output logic                        a_ready,
  input  logic signed [B_WIDTH-1:0]   b_data [B_COMPUTE_DIM0*B_COMPUTE_DIM1],
  input  logic                        b_valid,
  output logic                        b_ready,
  output logic signed [OUT_WIDTH-1:0] out_data [A_COMPUTE_DIM1*B_COMPUTE_DIM0],
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int DA0    = A_TOTAL_DIM0 / A_COMPUTE_DIM0;
  localparam int DA1    = A_TOTAL_DIM1 / A_COMPUTE_DIM1;
  localparam int DB0    = B_TOTAL_DIM0 / B_COMPUTE_DIM0;
  localparam int A_N    = A_COMPUTE_DIM0 * A_COMPUTE_DIM1;
  localparam int O_N    = A_COMPUTE_DIM1 * B_COMPUTE_DIM0;
  localparam int ACC_W  = A_WIDTH + B_WIDTH + $clog2(A_TOTAL_DIM0);
  localparam int SHIFT  = A_FRAC_WIDTH + B_FRAC_WIDTH - OUT_FRAC_WIDTH;
  localparam int RSH    = (SHIFT > 0) ? SHIFT : 0;
  localparam int LSH    = (SHIFT < 0) ? -SHIFT : 0;
  localparam int CAST_W = ACC_W + LSH;
  localparam int SAT_W  = ((CAST_W > OUT_WIDTH) ? CAST_W : OUT_WIDTH) + 1;
  localparam int IW     = (DA1 > 1) ? $clog2(DA1) : 1;
  localparam int KW     = (DA0 > 1) ? $clog2(DA0) : 1;
  localparam int JW     = (DB0 > 1) ? $clog2(DB0) : 1;

  localparam logic signed [SAT_W-1:0] SAT_MAX = SAT_W'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [SAT_W-1:0] SAT_MIN = SAT_W'(-(64'sd1 <<< (OUT_WIDTH - 1)));

  if ((A_TOTAL_DIM0 != B_TOTAL_DIM1) || (A_COMPUTE_DIM0 != B_COMPUTE_DIM1) ||
      (A_TOTAL_DIM0 % A_COMPUTE_DIM0 != 0) || (A_TOTAL_DIM1 % A_COMPUTE_DIM1 != 0) ||
      (B_TOTAL_DIM0 % B_COMPUTE_DIM0 != 0) || (B_TOTAL_DIM1 % B_COMPUTE_DIM1 != 0)) begin : g_bad_dims
    $fatal(1, "matmul: inconsistent matrix/tile dimensions");
  end

  typedef enum logic {
    S_LOAD_A,
    S_HOLD_A
  } state_e;

  state_e                   state_q, state_d;
  logic [IW-1:0]            i_q, i_d;
  logic [KW-1:0]            k_q, k_d;
  logic [JW-1:0]            j_q, j_d;
  logic signed [A_WIDTH-1:0] a_tile_q [A_N];
  logic signed [A_WIDTH-1:0] a_tile_d [A_N];
  logic signed [ACC_W-1:0]  acc_q [DB0][O_N];
  logic signed [ACC_W-1:0]  acc_d [DB0][O_N];
  logic signed [OUT_WIDTH-1:0] out_q [O_N];
  logic signed [OUT_WIDTH-1:0] out_d [O_N];
  logic                     out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0]  prod [O_N];
  logic                     last_i, last_k, last_j;

  // Floor-shift to the output fraction, then clamp to the signed output range.
  function automatic logic signed [OUT_WIDTH-1:0] cast_out(input logic signed [ACC_W-1:0] x);
    logic signed [CAST_W-1:0] v;
    logic signed [SAT_W-1:0]  w;
    v = CAST_W'(x);
    v = (v >>> RSH) <<< LSH;
    w = SAT_W'(v);
    if (w > SAT_MAX) w = SAT_MAX;
    else if (w < SAT_MIN) w = SAT_MIN;
    return OUT_WIDTH'(w);
  endfunction

  // Full-precision product of the held A tile with the B tile on the bus.
  always_comb begin
    for (int unsigned e = 0; e < O_N; e++) prod[e] = '0;
    for (int unsigned r = 0; r < A_COMPUTE_DIM1; r++) begin
      for (int unsigned c = 0; c < B_COMPUTE_DIM0; c++) begin
        for (int unsigned m = 0; m < A_COMPUTE_DIM0; m++) begin
          prod[r*B_COMPUTE_DIM0+c] = prod[r*B_COMPUTE_DIM0+c] +
            ACC_W'(a_tile_q[r*A_COMPUTE_DIM0+m]) * ACC_W'(b_data[m*B_COMPUTE_DIM0+c]);
        end
      end
    end
  end

  // Handshakes, tile counters, accumulate/emit and A-hold control.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    k_d         = k_q;
    j_d         = j_q;
    a_tile_d    = a_tile_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    last_i      = (i_q == IW'(DA1 - 1));
    last_k      = (k_q == KW'(DA0 - 1));
    last_j      = (j_q == JW'(DB0 - 1));
    a_ready     = rst && (state_q == S_LOAD_A);
    // Only the final k beat writes the output register, so only it waits for space.
    b_ready     = rst && (state_q == S_HOLD_A) && (!last_k || !out_valid_q || out_ready);

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (a_valid && a_ready) begin
      a_tile_d = a_data;
      state_d  = S_HOLD_A;
    end

    if (b_valid && b_ready) begin
      for (int unsigned j = 0; j < DB0; j++) begin
        if (j_q == JW'(j)) begin
          for (int unsigned e = 0; e < O_N; e++) begin
            if (last_k) begin
              out_d[e]    = cast_out(acc_q[j][e] + prod[e]);
              acc_d[j][e] = '0;
            end else begin
              acc_d[j][e] = acc_q[j][e] + prod[e];
            end
          end
        end
      end
      if (last_k) out_valid_d = 1'b1;
      if (last_j) begin
        j_d     = '0;
        state_d = S_LOAD_A;
        k_d     = last_k ? '0 : k_q + 1'b1;
        if (last_k) i_d = last_i ? '0 : i_q + 1'b1;
      end else begin
        j_d = j_q + 1'b1;
      end
    end
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_LOAD_A;
      i_q         <= '0;
      k_q         <= '0;
      j_q         <= '0;
      out_valid_q <= 1'b0;
      for (int unsigned e = 0; e < A_N; e++) a_tile_q[e] <= '0;
      for (int unsigned e = 0; e < O_N; e++) out_q[e] <= '0;
      for (int unsigned j = 0; j < DB0; j++) begin
        for (int unsigned e = 0; e < O_N; e++) acc_q[j][e] <= '0;
      end
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      k_q         <= k_d;
      j_q         <= j_d;
      out_valid_q <= out_valid_d;
      a_tile_q    <= a_tile_d;
      out_q       <= out_d;
      acc_q       <= acc_d;
    end
  end

  assign out_data  = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_matmul.sv
// tb_matmul: randomized self-checking bench for matmul against a plain
// whole-matrix reference (integer products, floor division, clamping).
module tb_matmul;

  localparam int DA0 = 2, DA1 = 2, DB0 = 2, BUDGET = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic signed [7:0]  a_data [4];
  logic signed [7:0]  b_data [4];
  logic signed [15:0] out_data [4];
  logic a_valid, a_ready, b_valid, b_ready, out_valid, out_ready;

  matmul dut (
    .clk(clk), .rst(rst),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  logic signed [7:0] s_a_data [1];
  logic signed [7:0] s_b_data [1];
  logic signed [7:0] s_out_data [1];
  logic s_a_valid, s_a_ready, s_b_valid, s_b_ready, s_out_valid, s_out_ready;

  matmul #(
    .A_TOTAL_DIM0(1), .A_TOTAL_DIM1(1), .B_TOTAL_DIM0(1), .B_TOTAL_DIM1(1),
    .A_COMPUTE_DIM0(1), .A_COMPUTE_DIM1(1), .B_COMPUTE_DIM0(1), .B_COMPUTE_DIM1(1),
    .OUT_WIDTH(8)
  ) u_sat (
    .clk(clk), .rst(rst),
    .a_data(s_a_data), .a_valid(s_a_valid), .a_ready(s_a_ready),
    .b_data(s_b_data), .b_valid(s_b_valid), .b_ready(s_b_ready),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready)
  );

  logic signed [7:0]  f_a_data [1];
  logic signed [7:0]  f_b_data [1];
  logic signed [15:0] f_out_data [1];
  logic f_a_valid, f_a_ready, f_b_valid, f_b_ready, f_out_valid, f_out_ready;

  matmul #(
    .A_TOTAL_DIM0(1), .A_TOTAL_DIM1(1), .B_TOTAL_DIM0(1), .B_TOTAL_DIM1(1),
    .A_COMPUTE_DIM0(1), .A_COMPUTE_DIM1(1), .B_COMPUTE_DIM0(1), .B_COMPUTE_DIM1(1),
    .A_FRAC_WIDTH(1), .B_FRAC_WIDTH(1), .OUT_FRAC_WIDTH(0)
  ) u_floor (
    .clk(clk), .rst(rst),
    .a_data(f_a_data), .a_valid(f_a_valid), .a_ready(f_a_ready),
    .b_data(f_b_data), .b_valid(f_b_valid), .b_ready(f_b_ready),
    .out_data(f_out_data), .out_valid(f_out_valid), .out_ready(f_out_ready)
  );

  int checks = 0, errors = 0;
  int ma [4][4];
  int mb [4][4];
  logic [31:0] aq [$];
  logic [31:0] bq [$];
  logic [63:0] expq [$];
  logic [63:0] got [$];
  int ctl_bad, stab_bad, stall_seen;
  bit timeout;

  function automatic int ref_cast(input int v, input int sh, input int ow);
    int d, q, hi, lo;
    q = v;
    if (sh > 0) begin
      d = 1 << sh;
      q = v / d;
      if ((v % d) != 0 && v < 0) q = q - 1;
    end else if (sh < 0) begin
      q = v * (1 << -sh);
    end
    hi = (1 << (ow - 1)) - 1;
    lo = -(1 << (ow - 1));
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return q;
  endfunction

  function automatic logic [63:0] pack_out();
    logic [63:0] v;
    for (int e = 0; e < 4; e++) v[16*e +: 16] = out_data[e];
    return v;
  endfunction

  task automatic clear_q();
    aq.delete(); bq.delete(); expq.delete();
  endtask

  // Append one matrix (ma x mb) as A stream, repeated B stream and expected tiles.
  task automatic build();
    logic [31:0] t;
    logic [63:0] o;
    int s;
    for (int i = 0; i < DA1; i++)
      for (int k = 0; k < DA0; k++) begin
        for (int r = 0; r < 2; r++)
          for (int m = 0; m < 2; m++) t[8*(r*2+m) +: 8] = 8'(ma[i*2+r][k*2+m]);
        aq.push_back(t);
      end
    for (int i = 0; i < DA1; i++)
      for (int k = 0; k < DA0; k++)
        for (int j = 0; j < DB0; j++) begin
          for (int m = 0; m < 2; m++)
            for (int c = 0; c < 2; c++) t[8*(m*2+c) +: 8] = 8'(mb[k*2+m][j*2+c]);
          bq.push_back(t);
        end
    for (int i = 0; i < DA1; i++)
      for (int j = 0; j < DB0; j++) begin
        for (int r = 0; r < 2; r++)
          for (int c = 0; c < 2; c++) begin
            s = 0;
            for (int m = 0; m < 4; m++) s += ma[i*2+r][m] * mb[m][j*2+c];
            o[16*(r*2+c) +: 16] = 16'(ref_cast(s, 0, 16));
          end
        expq.push_back(o);
      end
  endtask

  // Cycle-level driver/monitor: random gaps, optional 10-cycle output stall,
  // optional abort after stop_b B beats. Tallies protocol deviations.
  task automatic run(input int nout, input int gap, input bit bp, input int stop_b, output int cyc);
    int ap, bi, k, bpc;
    bit held, exp_b, ov_exp, hold_prev, af, bf;
    logic [31:0] t;
    logic [63:0] last_out;
    ap = 0; bi = 0; cyc = 0; ov_exp = 0; hold_prev = 0; last_out = '0;
    bpc = bp ? 10 : 0;
    ctl_bad = 0; stab_bad = 0; stall_seen = 0;
    got.delete();
    while (got.size() < nout && cyc < BUDGET && !(stop_b > 0 && bi >= stop_b)) begin
      @(negedge clk);
      if (out_valid !== ov_exp) ctl_bad++;
      if (hold_prev && pack_out() !== last_out) stab_bad++;
      if (bpc > 0 && (out_valid || bpc < 10)) begin
        out_ready = 1'b0;
        bpc--;
      end else begin
        out_ready = ($urandom_range(99) >= gap);
      end
      a_valid = (ap < aq.size()) && ($urandom_range(99) >= gap);
      if (a_valid) begin
        t = aq[ap];
        for (int e = 0; e < 4; e++) a_data[e] = t[8*e +: 8];
      end
      b_valid = (bi < bq.size()) && ($urandom_range(99) >= gap);
      if (b_valid) begin
        t = bq[bi];
        for (int e = 0; e < 4; e++) b_data[e] = t[8*e +: 8];
      end
      #1;
      held  = (ap > bi / DB0);
      k     = (bi / DB0) % DA0;
      exp_b = held && (k != DA0 - 1 || !out_valid || out_ready);
      if (a_ready !== !held) ctl_bad++;
      if (b_ready !== exp_b) ctl_bad++;
      if (out_valid && !out_ready && held && k == DA0 - 1 && b_ready === 1'b0) stall_seen++;
      af = a_valid && a_ready;
      bf = b_valid && b_ready;
      if (out_valid && out_ready) got.push_back(pack_out());
      ov_exp    = (bf && k == DA0 - 1) ? 1'b1 : ((out_valid && out_ready) ? 1'b0 : ov_exp);
      hold_prev = out_valid && !out_ready;
      last_out  = pack_out();
      if (af) ap++;
      if (bf) bi++;
      cyc++;
    end
    timeout = (cyc >= BUDGET);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready: got %b expected 0", a_ready); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL reset_b_ready: got %b expected 0", b_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL post_reset_a_ready: got %b expected 1", a_ready); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL post_reset_b_ready: got %b expected 0", b_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic set_identity();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = (r == c) ? 1 : 0;
        mb[r][c] = r * 4 + c + 1;
      end
  endtask

  task automatic test_identity();
    int cyc;
    set_identity();
    clear_q();
    build();
    run(4, 0, 1'b0, 0, cyc);
    checks++; if (timeout) begin errors++; $display("FAIL ident_timeout: got %0d cycles expected < %0d", cyc, BUDGET); end
    checks++; if (ctl_bad != 0) begin errors++; $display("FAIL ident_handshake: got %0d deviations expected 0", ctl_bad); end
    checks++; if (cyc != DA1 * DA0 * (1 + DB0) + 1) begin errors++; $display("FAIL ident_throughput: got %0d cycles expected %0d", cyc, DA1 * DA0 * (1 + DB0) + 1); end
    checks++;
    if (got.size() != 4) begin
      errors++; $display("FAIL ident_count: got %0d tiles expected 4", got.size());
    end else begin
      checks++; if (got[0] !== 64'h0006_0005_0002_0001) begin errors++; $display("FAIL ident_tile00: got %h expected %h", got[0], 64'h0006_0005_0002_0001); end
      checks++; if (got[3] !== 64'h0010_000f_000c_000b) begin errors++; $display("FAIL ident_tile11: got %h expected %h", got[3], 64'h0010_000f_000c_000b); end
      for (int t = 0; t < 4; t++) begin
        checks++; if (got[t] !== expq[t]) begin errors++; $display("FAIL ident_tile%0d: got %h expected %h", t, got[t], expq[t]); end
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    set_identity();
    clear_q();
    build();
    run(4, 0, 1'b1, 0, cyc);
    checks++; if (timeout) begin errors++; $display("FAIL bp_timeout: got %0d cycles expected < %0d", cyc, BUDGET); end
    checks++; if (ctl_bad != 0) begin errors++; $display("FAIL bp_handshake: got %0d deviations expected 0", ctl_bad); end
    checks++; if (stab_bad != 0) begin errors++; $display("FAIL bp_stable: got %0d changes expected 0", stab_bad); end
    checks++; if (stall_seen == 0) begin errors++; $display("FAIL bp_b_stall: got %0d stalled cycles expected > 0", stall_seen); end
    checks++;
    if (got.size() != 4) begin
      errors++; $display("FAIL bp_count: got %0d tiles expected 4", got.size());
    end else begin
      for (int t = 0; t < 4; t++) begin
        checks++; if (got[t] !== expq[t]) begin errors++; $display("FAIL bp_tile%0d: got %h expected %h", t, got[t], expq[t]); end
      end
    end
  endtask

  task automatic test_random();
    int cyc, v, n;
    clear_q();
    for (int mtx = 0; mtx < 50; mtx++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (mtx % 10 == 0) begin
            ma[r][c] = $urandom_range(1) ? 127 : -128;
            mb[r][c] = $urandom_range(1) ? 127 : -128;
          end else begin
            v = $urandom_range(255); ma[r][c] = v - 128;
            v = $urandom_range(255); mb[r][c] = v - 128;
          end
        end
      build();
    end
    run(expq.size(), 30, 1'b0, 0, cyc);
    checks++; if (timeout) begin errors++; $display("FAIL rand_timeout: got %0d cycles expected < %0d", cyc, BUDGET); end
    checks++; if (ctl_bad != 0) begin errors++; $display("FAIL rand_handshake: got %0d deviations expected 0", ctl_bad); end
    checks++; if (stab_bad != 0) begin errors++; $display("FAIL rand_stable: got %0d changes expected 0", stab_bad); end
    checks++; if (got.size() != expq.size()) begin errors++; $display("FAIL rand_count: got %0d tiles expected %0d", got.size(), expq.size()); end
    n = (got.size() < expq.size()) ? got.size() : expq.size();
    for (int t = 0; t < n; t++) begin
      checks++; if (got[t] !== expq[t]) begin errors++; $display("FAIL rand_tile%0d: got %h expected %h", t, got[t], expq[t]); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, v;
    clear_q();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        v = $urandom_range(255); ma[r][c] = v - 128;
        v = $urandom_range(255); mb[r][c] = v - 128;
      end
    build();
    run(expq.size(), 0, 1'b0, 3, cyc);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_b_ready: got %b expected 0", b_ready); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL mid_post_a_ready: got %b expected 1", a_ready); end
    clear_q();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = 1;
        mb[r][c] = 1;
      end
    build();
    run(4, 0, 1'b0, 0, cyc);
    checks++; if (timeout) begin errors++; $display("FAIL mid_timeout: got %0d cycles expected < %0d", cyc, BUDGET); end
    checks++; if (ctl_bad != 0) begin errors++; $display("FAIL mid_handshake: got %0d deviations expected 0", ctl_bad); end
    checks++;
    if (got.size() != 4) begin
      errors++; $display("FAIL mid_count: got %0d tiles expected 4", got.size());
    end else begin
      for (int t = 0; t < 4; t++) begin
        checks++; if (got[t] !== 64'h0004_0004_0004_0004) begin errors++; $display("FAIL mid_tile%0d: got %h expected %h", t, got[t], 64'h0004_0004_0004_0004); end
      end
    end
  endtask

  task automatic txn_sat(input logic signed [7:0] av, input logic signed [7:0] bv,
                         output logic signed [7:0] res, output bit ok);
    int n;
    ok = 1'b1;
    @(negedge clk); s_a_data[0] = av; s_a_valid = 1'b1; #1;
    n = 0; while (!s_a_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) ok = 1'b0;
    @(negedge clk); s_a_valid = 1'b0; s_b_data[0] = bv; s_b_valid = 1'b1; #1;
    n = 0; while (!s_b_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) ok = 1'b0;
    @(negedge clk); s_b_valid = 1'b0; #1;
    n = 0; while (!s_out_valid && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) ok = 1'b0;
    res = s_out_data[0];
    s_out_ready = 1'b1;
    @(negedge clk); s_out_ready = 1'b0;
  endtask

  task automatic txn_floor(input logic signed [7:0] av, input logic signed [7:0] bv,
                           output logic signed [15:0] res, output bit ok);
    int n;
    ok = 1'b1;
    @(negedge clk); f_a_data[0] = av; f_a_valid = 1'b1; #1;
    n = 0; while (!f_a_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) ok = 1'b0;
    @(negedge clk); f_a_valid = 1'b0; f_b_data[0] = bv; f_b_valid = 1'b1; #1;
    n = 0; while (!f_b_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) ok = 1'b0;
    @(negedge clk); f_b_valid = 1'b0; #1;
    n = 0; while (!f_out_valid && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) ok = 1'b0;
    res = f_out_data[0];
    f_out_ready = 1'b1;
    @(negedge clk); f_out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    logic signed [7:0] res;
    bit ok;
    txn_sat(8'sd100, 8'sd2, res, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sat_pos_handshake: got timeout expected completion"); end
    checks++; if (res !== 8'sd127) begin errors++; $display("FAIL sat_pos: got %0d expected 127", res); end
    txn_sat(-8'sd100, 8'sd2, res, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sat_neg_handshake: got timeout expected completion"); end
    checks++; if (res !== -8'sd128) begin errors++; $display("FAIL sat_neg: got %0d expected -128", res); end
  endtask

  task automatic test_floor();
    logic signed [15:0] res;
    bit ok;
    txn_floor(8'sd1, 8'sd1, res, ok);
    checks++; if (!ok) begin errors++; $display("FAIL floor_pos_handshake: got timeout expected completion"); end
    checks++; if (res !== 16'sd0) begin errors++; $display("FAIL floor_pos: got %0d expected 0", res); end
    txn_floor(-8'sd1, 8'sd1, res, ok);
    checks++; if (!ok) begin errors++; $display("FAIL floor_neg_handshake: got timeout expected completion"); end
    checks++; if (res !== -16'sd1) begin errors++; $display("FAIL floor_neg: got %0d expected -1", res); end
  endtask

  initial begin
    rst = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    for (int e = 0; e < 4; e++) begin a_data[e] = '0; b_data[e] = '0; end
    s_a_valid = 1'b0; s_b_valid = 1'b0; s_out_ready = 1'b0; s_a_data[0] = '0; s_b_data[0] = '0;
    f_a_valid = 1'b0; f_b_valid = 1'b0; f_out_ready = 1'b0; f_a_data[0] = '0; f_b_data[0] = '0;
    test_reset();
    test_identity();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_saturation();
    test_floor();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
